// File: rtl/fgyrus_pkg.sv
// Shared types and address helper for the fgyrus FFT butterfly scheduler.
// Holds the scheduler FSM encoding, the writeback FIFO entry and the per-butterfly address map.
package fgyrus_pkg;

    localparam int FG_NUM_SAMPLES = 128;
    localparam int FG_ADDR_W      = $clog2(FG_NUM_SAMPLES);
    localparam int FG_TWDL_ADDR_W = FG_ADDR_W - 1;
    localparam int FG_STG_W       = $clog2(FG_ADDR_W);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE_A,
        ST_ISSUE_B,
        ST_DRAIN,
        ST_FIN
    } sched_state_t;

    typedef struct packed {
        logic [FG_ADDR_W-1:0] addr_a;
        logic [FG_ADDR_W-1:0] addr_b;
    } wb_entry_t;

    typedef struct packed {
        logic [FG_ADDR_W-1:0]      addr_a;
        logic [FG_ADDR_W-1:0]      addr_b;
        logic [FG_TWDL_ADDR_W-1:0] twdl;
    } but_addr_t;

    // In-place radix-2 DIT pairing: butterfly k of stage s straddles a group of 2*half samples.
    function automatic but_addr_t but_addr(input logic [FG_STG_W-1:0] s,
                                           input logic [FG_ADDR_W-2:0] k);
        but_addr_t            r;
        logic [FG_ADDR_W-1:0] half;
        logic [FG_ADDR_W-1:0] pos;
        logic [FG_ADDR_W-1:0] grp;
        half     = FG_ADDR_W'(1) << s;
        pos      = {1'b0, k} & (half - FG_ADDR_W'(1));
        grp      = {1'b0, k} >> s;
        r.addr_a = (grp << (s + FG_STG_W'(1))) | pos;
        r.addr_b = r.addr_a + half;
        r.twdl   = FG_TWDL_ADDR_W'(pos << (FG_ADDR_W - 1 - int'(s)));
        return r;
    endfunction

endpackage

// File: rtl/fgyrus_wb_fifo.sv
// Writeback address FIFO: holds {addr_a, addr_b} of each issued butterfly until its results return.
module fgyrus_wb_fifo
    import fgyrus_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush_i,
    input  logic                     push_i,
    input  wb_entry_t                din_i,
    input  logic                     pop_i,
    output wb_entry_t                dout_o,
    output logic                     empty_o,
    output logic                     full_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    wb_entry_t        mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] cnt_q;
    logic             do_push, do_pop;

    assign empty_o = (cnt_q == '0);
    assign full_o  = (cnt_q == CNT_W'(DEPTH));
    assign count_o = cnt_q;
    assign dout_o  = mem_q[rd_ptr_q];
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            cnt_q <= cnt_q + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= din_i;
    end

endmodule

// File: rtl/fgyrus_but_sched.sv
// Butterfly scheduler: walks all stages of an in-place radix-2 FFT, issues cache/twiddle reads
// and writes the butterfly wing results back in issue order.
module fgyrus_but_sched
    import fgyrus_pkg::*;
#(
    parameter int NUM_SAMPLES = FG_NUM_SAMPLES,
    parameter int ADDR_W      = FG_ADDR_W,
    parameter int TWDL_ADDR_W = FG_TWDL_ADDR_W,
    parameter int MEM_RD_DEL  = 2,
    parameter int MAX_OUTST   = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start_i,
    input  logic                   abort_i,
    output logic                   busy_o,
    output logic                   done_o,
    output logic                   wb_err_o,
    output logic                   cache_rden_o,
    output logic [ADDR_W-1:0]      cache_raddr_o,
    output logic                   cache_wren_o,
    output logic [ADDR_W-1:0]      cache_waddr_o,
    output logic                   twdl_rden_o,
    output logic [TWDL_ADDR_W-1:0] twdl_addr_o,
    output logic                   bw_start_o,
    input  logic                   res_vld_i
);

    localparam int K_W   = $clog2(NUM_SAMPLES) - 1;
    localparam int CNT_W = $clog2(MAX_OUTST) + 1;

    sched_state_t          state_q, state_d;
    logic [FG_STG_W-1:0]   s_q, s_d;
    logic [K_W-1:0]        k_q, k_d;
    but_addr_t             ba;
    logic                  issue_a, issue_b;
    logic                  fifo_empty, fifo_full, fifo_pop, wr_en;
    logic [CNT_W-1:0]      fifo_cnt;
    wb_entry_t             fifo_din, fifo_head;
    logic                  tgl_q, wb_err_q;
    logic [MEM_RD_DEL-1:0] vld_pipe_q;

    assign ba      = but_addr(s_q, k_q);
    assign issue_a = (state_q == ST_ISSUE_A) && !fifo_full;
    assign issue_b = (state_q == ST_ISSUE_B);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            s_q     <= '0;
            k_q     <= '0;
        end else begin
            state_q <= state_d;
            s_q     <= s_d;
            k_q     <= k_d;
        end
    end

    always_comb begin
        state_d = state_q;
        s_d     = s_q;
        k_d     = k_q;
        if (abort_i) begin
            state_d = ST_IDLE;
        end else begin
            unique case (state_q)
                ST_IDLE: if (start_i) begin
                    state_d = ST_ISSUE_A;
                    s_d     = '0;
                    k_d     = '0;
                end
                ST_ISSUE_A: if (!fifo_full) state_d = ST_ISSUE_B;
                ST_ISSUE_B: begin
                    k_d     = k_q + K_W'(1);
                    state_d = (k_q == {K_W{1'b1}}) ? ST_DRAIN : ST_ISSUE_A;
                end
                // Next stage reads what this stage writes, so everything must land first.
                ST_DRAIN: if (fifo_cnt == '0) begin
                    if (s_q == FG_STG_W'(ADDR_W - 1)) begin
                        state_d = ST_FIN;
                    end else begin
                        s_d     = s_q + FG_STG_W'(1);
                        k_d     = '0;
                        state_d = ST_ISSUE_A;
                    end
                end
                ST_FIN:  state_d = ST_IDLE;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        cache_rden_o  = issue_a || issue_b;
        cache_raddr_o = '0;
        twdl_rden_o   = issue_a;
        twdl_addr_o   = '0;
        busy_o        = (state_q != ST_IDLE) && (state_q != ST_FIN);
        done_o        = (state_q == ST_FIN);
        if (issue_a) begin
            cache_raddr_o = ADDR_W'(ba.addr_a);
            twdl_addr_o   = TWDL_ADDR_W'(ba.twdl);
        end else if (issue_b) begin
            cache_raddr_o = ADDR_W'(ba.addr_b);
        end
    end

    assign fifo_din.addr_a = ba.addr_a;
    assign fifo_din.addr_b = ba.addr_b;

    fgyrus_wb_fifo #(.DEPTH(MAX_OUTST)) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .flush_i (abort_i),
        .push_i  (issue_b),
        .din_i   (fifo_din),
        .pop_i   (fifo_pop),
        .dout_o  (fifo_head),
        .empty_o (fifo_empty),
        .full_o  (fifo_full),
        .count_o (fifo_cnt)
    );

    // Results come as an A/B pair; the toggle picks the head entry's half.
    assign wr_en         = res_vld_i && !fifo_empty;
    assign fifo_pop      = wr_en && tgl_q;
    assign cache_wren_o  = wr_en;
    assign cache_waddr_o = tgl_q ? ADDR_W'(fifo_head.addr_b) : ADDR_W'(fifo_head.addr_a);
    assign bw_start_o    = vld_pipe_q[MEM_RD_DEL-1];
    assign wb_err_o      = wb_err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tgl_q      <= 1'b0;
            vld_pipe_q <= '0;
            wb_err_q   <= 1'b0;
        end else begin
            if (abort_i) begin
                tgl_q      <= 1'b0;
                vld_pipe_q <= '0;
            end else begin
                if (wr_en) tgl_q <= ~tgl_q;
                vld_pipe_q <= (vld_pipe_q << 1) | MEM_RD_DEL'(issue_b);
            end
            if (state_q == ST_IDLE && start_i && !abort_i) wb_err_q <= 1'b0;
            if (res_vld_i && fifo_empty) wb_err_q <= 1'b1;
        end
    end

endmodule

// File: tb/tb_fgyrus_but_sched.sv
// Directed bench for fgyrus_but_sched with a latency-programmable butterfly wing model.
module tb_fgyrus_but_sched;

    logic       clk, rst_n, start_i, abort_i, res_vld_i;
    logic       busy_o, done_o, wb_err_o, cache_rden_o, cache_wren_o, twdl_rden_o, bw_start_o;
    logic [6:0] cache_raddr_o, cache_waddr_o;
    logic [5:0] twdl_addr_o;

    fgyrus_but_sched dut (
        .clk(clk), .rst_n(rst_n), .start_i(start_i), .abort_i(abort_i),
        .busy_o(busy_o), .done_o(done_o), .wb_err_o(wb_err_o),
        .cache_rden_o(cache_rden_o), .cache_raddr_o(cache_raddr_o),
        .cache_wren_o(cache_wren_o), .cache_waddr_o(cache_waddr_o),
        .twdl_rden_o(twdl_rden_o), .twdl_addr_o(twdl_addr_o),
        .bw_start_o(bw_start_o), .res_vld_i(res_vld_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0, n_err = 0;
    int cyc = 0, lat = 4;
    bit sched [256];
    bit force_vld = 1'b0;
    int rd_q[$], rd_cyc[$], tw_q[$], wr_q[$], pop_cyc[$];
    int issued = 0, pops = 0, bw_cnt = 0, done_cnt = 0, busy_at_done = -1;

    task automatic chk(input string tag, input int obs, input int exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Wing model and output logger: res_vld driven at the falling edge, outputs sampled 1 later.
    always begin
        @(negedge clk);
        res_vld_i = sched[cyc % 256] | force_vld;
        sched[cyc % 256] = 1'b0;
        #1;
        if (cache_rden_o) begin
            rd_q.push_back(int'(cache_raddr_o));
            rd_cyc.push_back(cyc);
            if (rd_q.size() % 2 == 0) issued++;
        end
        if (twdl_rden_o) tw_q.push_back(int'(twdl_addr_o));
        if (cache_wren_o) begin
            wr_q.push_back(int'(cache_waddr_o));
            if (wr_q.size() % 2 == 0) begin
                pops++;
                pop_cyc.push_back(cyc);
            end
        end
        if (bw_start_o) begin
            bw_cnt++;
            sched[(cyc + lat) % 256]     = 1'b1;
            sched[(cyc + lat + 1) % 256] = 1'b1;
        end
        if (done_o) begin
            done_cnt++;
            busy_at_done = int'(busy_o);
        end
        if (abort_i || !rst_n) for (int i = 0; i < 256; i++) sched[i] = 1'b0;
        cyc++;
    end

    task automatic pulse_start();
        @(negedge clk); start_i = 1'b1;
        @(negedge clk); start_i = 1'b0;
    endtask

    task automatic wait_done(input int done_base, input int budget, output int mx);
        int n = 0;
        mx = 0;
        while (done_cnt == done_base && n < budget) begin
            @(negedge clk); #2;
            if (issued - pops > mx) mx = issued - pops;
            n++;
        end
        chk("done_in_budget", int'(n < budget), 1);
    endtask

    int rb, wb, tb, bb, db, pb, mx, n, h, a, t;

    initial begin
        rst_n = 1'b0; start_i = 1'b0; abort_i = 1'b0;
        repeat (3) @(negedge clk);
        #2;
        chk("rst_busy", busy_o, 0);
        chk("rst_done", done_o, 0);
        chk("rst_rden", cache_rden_o, 0);
        chk("rst_wren", cache_wren_o, 0);
        chk("rst_bw_start", bw_start_o, 0);
        chk("rst_wb_err", wb_err_o, 0);
        @(negedge clk); rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Full FFT with an ideal wing
        lat = 4;
        rb = rd_q.size(); wb = wr_q.size(); tb = tw_q.size(); bb = bw_cnt; db = done_cnt;
        pulse_start();
        wait_done(db, 20000, mx);
        repeat (2) @(negedge clk);
        chk("s0_rd0", rd_q[rb+0], 0);
        chk("s0_rd1", rd_q[rb+1], 1);
        chk("s0_rd2", rd_q[rb+2], 2);
        chk("s0_rd3", rd_q[rb+3], 3);
        chk("s6k0_rd_a", rd_q[rb+768], 0);
        chk("s6k0_rd_b", rd_q[rb+769], 64);
        chk("s6k1_rd_a", rd_q[rb+770], 1);
        chk("s6k1_rd_b", rd_q[rb+771], 65);
        chk("s6k0_twdl", tw_q[tb+384], 0);
        chk("s6k1_twdl", tw_q[tb+385], 1);
        chk("s2k5_rd_a", rd_q[rb+266], 9);
        chk("s2k5_rd_b", rd_q[rb+267], 13);
        chk("s2k5_twdl", tw_q[tb+133], 16);
        chk("s2k5_wr_a", wr_q[wb+266], 9);
        chk("s2k5_wr_b", wr_q[wb+267], 13);
        chk("n_reads", rd_q.size() - rb, 896);
        chk("n_twdl", tw_q.size() - tb, 448);
        chk("n_bw_start", bw_cnt - bb, 448);
        chk("n_writes", wr_q.size() - wb, 896);
        chk("n_done", done_cnt - db, 1);
        chk("busy_at_done", busy_at_done, 0);
        if (rd_q.size() - rb == 896 && wr_q.size() - wb == 896 && tw_q.size() - tb == 448) begin
            for (int s = 0; s < 7; s++) begin
                for (int k = 0; k < 64; k++) begin
                    h = 1 << s;
                    a = (k / h) * 2 * h + (k % h);
                    t = (k % h) * (64 / h);
                    n = s * 128 + 2 * k;
                    chk($sformatf("rd s%0d k%0d a", s, k), rd_q[rb+n], a);
                    chk($sformatf("rd s%0d k%0d b", s, k), rd_q[rb+n+1], a + h);
                    chk($sformatf("wr s%0d k%0d a", s, k), wr_q[wb+n], a);
                    chk($sformatf("wr s%0d k%0d b", s, k), wr_q[wb+n+1], a + h);
                    chk($sformatf("tw s%0d k%0d", s, k), tw_q[tb+s*64+k], t);
                end
            end
        end

        // Slow wing: outstanding limit and stage drain
        lat = 40;
        rb = rd_q.size(); wb = wr_q.size(); db = done_cnt; pb = pop_cyc.size();
        pulse_start();
        wait_done(db, 20000, mx);
        chk("slow_max_outst", mx, 4);
        chk("slow_stall_gap", int'(rd_cyc[rb+8] - rd_cyc[rb+7] > 30), 1);
        chk("slow_s1_after_pop64", int'(rd_cyc[rb+128] > pop_cyc[pb+63]), 1);
        chk("slow_n_writes", wr_q.size() - wb, 896);
        chk("slow_n_done", done_cnt - db, 1);
        repeat (2) @(negedge clk);

        // Abort mid stage 3 with three butterflies outstanding
        rb = rd_q.size(); db = done_cnt;
        pulse_start();
        n = 0;
        while (rd_q.size() < rb + 390 && n < 20000) begin
            @(negedge clk); #2;
            n++;
        end
        chk("abort_reach_s3", int'(n < 20000), 1);
        @(negedge clk); abort_i = 1'b1;
        #2;
        chk("outst_at_abort", issued - pops, 3);
        @(negedge clk); abort_i = 1'b0;
        #2;
        chk("abort_busy", busy_o, 0);
        chk("abort_bw_start", bw_start_o, 0);
        wb = wr_q.size();
        repeat (60) @(negedge clk);
        #2;
        chk("abort_no_done", done_cnt - db, 0);
        chk("abort_no_writes", wr_q.size() - wb, 0);
        chk("abort_no_wb_err", wb_err_o, 0);

        // Spurious result while idle (also shows the FIFO was flushed)
        @(posedge clk); #1 force_vld = 1'b1;
        @(negedge clk); #2;
        chk("spur_wren", cache_wren_o, 0);
        @(posedge clk); #1 force_vld = 1'b0;
        #1;
        chk("spur_wb_err", wb_err_o, 1);
        repeat (2) @(negedge clk);

        // Restart after abort clears wb_err and begins at stage 0
        lat = 4;
        rb = rd_q.size();
        pulse_start();
        #2;
        chk("restart_wb_err", wb_err_o, 0);
        repeat (3) @(negedge clk);
        chk("restart_rd0", rd_q[rb], 0);
        chk("restart_rd1", rd_q[rb+1], 1);

        // Asynchronous reset while ISSUE_B drives the bus
        n = 0;
        do begin
            @(negedge clk); #2;
            n++;
        end while (!(cache_rden_o && (rd_q.size() - rb) % 2 == 0 && rd_q.size() - rb > 20) && n < 2000);
        chk("reach_issue_b", int'(n < 2000), 1);
        rst_n = 1'b0;
        #1;
        chk("arst_busy", busy_o, 0);
        chk("arst_rden", cache_rden_o, 0);
        chk("arst_raddr", int'(cache_raddr_o), 0);
        chk("arst_twdl_rden", twdl_rden_o, 0);
        chk("arst_twdl_addr", int'(twdl_addr_o), 0);
        chk("arst_bw_start", bw_start_o, 0);
        chk("arst_wren", cache_wren_o, 0);
        chk("arst_done", done_o, 0);
        chk("arst_wb_err", wb_err_o, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        rb = rd_q.size();
        repeat (3) @(negedge clk);
        #2;
        chk("post_rst_busy", busy_o, 0);
        chk("post_rst_no_reads", rd_q.size() - rb, 0);
        pulse_start();
        repeat (3) @(negedge clk);
        chk("post_rst_rd0", rd_q[rb], 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
